axis_rs232rx: RTL and testbench
===============================

Name: axis_rs232rx

Overview:
RS-232 8N1 receiver with an AXI-stream style byte output. It samples the asynchronous rxd_pin and produces one byte per valid frame on odata/ovalid/oready. It drives RTSn toward the remote transmitter, whose CTSn input throttles its sending. It pairs with axis_rs232tx at the opposite end of a UART link.

Parameters:
CLOCK_FREQ  133000000  clock frequency in Hz (real)
BAUD_RATE  115200  line rate in baud (real)

Ports:
clock  input  1  system clock, all logic on rising edge
resetn  input  1  reset, asynchronous, active-low
odata  output  8  received byte, LSB first on the line
ovalid  output  1  odata holds an unconsumed byte
oready  input  1  downstream accepts odata when ovalid && oready
rxd_pin  input  1  serial data, connected to TXD of the remote transmitter; idle high
rtsn_pin  output  1  active-low request-to-send, connected to CTSn of the remote transmitter
frame_err  output  1  one-cycle pulse: stop bit sampled low
overrun  output  1  one-cycle pulse: good frame dropped because the output was still full

Behaviour:
- Reset is asynchronous: reset, asynchronous, active-low on resetn; clock is clock.
- Reset values:
  - odata = 8'h00, ovalid = 0, rtsn_pin = 1, frame_err = 0, overrun = 0.
  - Both synchroniser flops = 1.
  - State = IDLE.
- rxd_pin passes through a 2-flop synchroniser, reset to 1; rxs is the synchronised value. All line decisions use rxs only.
- Timing constants, integer, truncated:
  - BAUD_COUNT = CLOCK_FREQ/BAUD_RATE.
  - HALF = BAUD_COUNT/2.
  - The counter is wide enough to hold BAUD_COUNT-1.
- Sample times: let t0 be the first cycle in IDLE with rxs == 0.
  - Start bit is sampled at t0+HALF.
  - Data bit i (i = 0..7) is sampled at t0+HALF+(i+1)*BAUD_COUNT.
  - Stop bit is sampled at t0+HALF+9*BAUD_COUNT.
- States:
  - IDLE: wait for rxs == 0; load the counter for HALF, then go to START.
  - START: at the start sample, rxs == 0 -> DATA with bit index 0. rxs == 1 -> IDLE (glitch rejected, no output, no error).
  - DATA: at each bit sample, shift rxs into the shift register MSB, shifting right (LSB first on the line). After bit 7 -> STOP.
  - STOP: at the stop sample, the next state depends on rxs and the output register (see frame outcomes below).
  - BREAK: stay while rxs == 0; rxs == 1 -> IDLE.
- Frame outcomes at the stop sample:
  - rxs == 1 and output free (ovalid == 0, or ovalid && oready that same cycle): odata <= shift register and ovalid <= 1 next cycle; go to IDLE.
  - rxs == 1 and output full (ovalid && !oready): overrun pulses for 1 cycle, the byte is dropped, odata is unchanged; go to IDLE.
  - rxs == 0: frame_err pulses for 1 cycle, the byte is discarded, ovalid/odata are untouched; go to BREAK.
- Latency: ovalid rises on the cycle after the stop sample, i.e. the stop sample cycle + 1.
- Output handshake:
  - ovalid && oready clears ovalid next cycle unless a new byte is loaded in that same cycle; a simultaneous load keeps ovalid = 1 with the new odata.
  - odata is stable while ovalid && !oready.
- Flow control:
  - rtsn_pin is registered and equals the previous cycle's ovalid: high while a byte is pending, low when empty.
  - rtsn_pin is 1 through reset and falls the first cycle after resetn deasserts.
  - It is advisory only; the receiver never stops sampling.
- Re-arm: IDLE is re-entered at the stop sample, so a start edge on the next cycle is caught. Back-to-back frames without idle time are supported.
- Reset mid-frame: all state returns to reset values immediately; a partial frame is lost and produces no pulse.

Test Plan:
Bench uses CLOCK_FREQ=1000000, BAUD_RATE=100000, giving BAUD_COUNT=10 and HALF=5.
- Single byte: send 0xA5 8N1 with oready=1 -> ovalid high exactly 1 cycle, odata=0xA5; ovalid rises at t0+96; rtsn_pin high for 1 cycle, 1 cycle after ovalid.
- Backpressure: oready=0, send 0x3C then 0x7E -> odata stays 0x3C with ovalid=1 and rtsn_pin=1; overrun pulses once at the second stop sample. Then oready=1 -> 0x3C consumed, ovalid=0 next cycle.
- Glitch: rxd_pin low for 3 cycles, then high -> no ovalid, no frame_err; the next byte 0x01 is received correctly.
- Framing/break: 0x55 with stop bit 0, line held low for 40 more cycles -> frame_err pulses once, no ovalid; after the line goes high, 0xC3 is received correctly.
- Back-to-back with a simultaneous drain: stream 0x00, 0xFF, 0x81 with no idle bits and oready=1 -> three ovalid pulses, data in order, no overrun.
- Reset mid-frame: assert resetn=0 during data bit 4 -> outputs return to reset values at once; after release, rtsn_pin=0 and the next full frame 0x42 is received.

Source files
------------

// File: rtl/axis_rs232rx.sv
// RS-232 8N1 receiver to byte stream; ovalid rises the cycle after the stop-bit sample.
// Backpressure: rtsn_pin mirrors pending output; a good frame arriving while full is dropped with an overrun pulse.
`timescale 1ns/1ps
module axis_rs232rx #(
  parameter real CLOCK_FREQ = 133000000.0,
  parameter real BAUD_RATE  = 115200.0
) (
  input  logic       clock,
  input  logic       resetn,
  output logic [7:0] odata,
  output logic       ovalid,
  input  logic       oready,
  input  logic       rxd_pin,
  output logic       rtsn_pin,
  output logic       frame_err,
  output logic       overrun
);

  localparam int BAUD_COUNT = $rtoi(CLOCK_FREQ / BAUD_RATE);
  localparam int HALF       = BAUD_COUNT / 2;
  localparam int CW         = (BAUD_COUNT > 2) ? $clog2(BAUD_COUNT) : 1;
  localparam logic [CW-1:0] HALF_LD = CW'(HALF - 1);
  localparam logic [CW-1:0] BAUD_LD = CW'(BAUD_COUNT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          rx_meta;
  logic          rxs;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rxd_pin;
      rxs     <= rx_meta;
    end
  end

  // Counter is loaded on the cycle a state is entered and the sample is taken when it reaches zero.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      odata     <= 8'h00;
      ovalid    <= 1'b0;
      rtsn_pin  <= 1'b1;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      rtsn_pin  <= ovalid;
      if (ovalid && oready) ovalid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rxs) begin
            cnt   <= HALF_LD;
            state <= START;
          end
        end
        START: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (!rxs) begin
            cnt     <= BAUD_LD;
            bit_idx <= 3'd0;
            state   <= DATA;
          end else begin
            state <= IDLE;
          end
        end
        DATA: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            shreg   <= {rxs, shreg[7:1]};
            cnt     <= BAUD_LD;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end
        end
        STOP: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else if (rxs) begin
            // A drain in this same cycle frees the slot for the new byte.
            if (!ovalid || oready) begin
              odata  <= shreg;
              ovalid <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
            state <= IDLE;
          end else begin
            frame_err <= 1'b1;
            state     <= BREAK;
          end
        end
        BREAK: begin
          if (rxs) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_rs232rx.sv
// Bench for axis_rs232rx: directed frame table, hand sequences and randomized frames
// checked every cycle against a frame-level reference model.
`timescale 1ns/1ps
module tb_axis_rs232rx;

  localparam int BC   = 10;
  localparam int HALF = 5;
  // Start bit driven after edge n: rxs low from edge n+2, first IDLE decision at n+3, stop sample HALF+9*BC later.
  localparam int STOP_OFS = 3 + HALF + 9 * BC;

  logic       clock   = 1'b0;
  logic       resetn  = 1'b0;
  logic       oready  = 1'b0;
  logic       rxd_pin = 1'b1;
  logic [7:0] odata;
  logic       ovalid;
  logic       rtsn_pin;
  logic       frame_err;
  logic       overrun;

  axis_rs232rx #(.CLOCK_FREQ(1000000.0), .BAUD_RATE(100000.0)) dut (
    .clock    (clock),
    .resetn   (resetn),
    .odata    (odata),
    .ovalid   (ovalid),
    .oready   (oready),
    .rxd_pin  (rxd_pin),
    .rtsn_pin (rtsn_pin),
    .frame_err(frame_err),
    .overrun  (overrun)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Stop-sample events keyed by the edge number at which the sample happens: 1 = good stop, 2 = bad stop.
  int         ev_kind[int];
  logic [7:0] ev_dat[int];

  logic       m_vld, m_rts, m_ferr, m_ovr;
  logic [7:0] m_dat;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      m_vld  <= 1'b0;
      m_dat  <= 8'h00;
      m_rts  <= 1'b1;
      m_ferr <= 1'b0;
      m_ovr  <= 1'b0;
    end else begin
      m_rts  <= m_vld;
      m_ferr <= 1'b0;
      m_ovr  <= 1'b0;
      m_vld  <= m_vld && !oready;
      if (ev_kind.exists(cyc + 1)) begin
        if (ev_kind[cyc + 1] == 1) begin
          if (!m_vld || oready) begin
            m_vld <= 1'b1;
            m_dat <= ev_dat[cyc + 1];
          end else begin
            m_ovr <= 1'b1;
          end
        end else begin
          m_ferr <= 1'b1;
        end
      end
    end
  end

  int checks = 0;
  int fails  = 0;
  bit rdy_mode = 1'b0;
  logic rdy_val = 1'b0;
  int rdy_pct = 50;

  typedef struct {
    logic [7:0] dat;
    logic       stop;
    int         glitch;
    int         brk;
    int         gap;
    logic       rdy;
    logic       exp_vld;
    logic [7:0] exp_dat;
    logic       exp_ferr;
    logic       exp_ovr;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    check("monitor {ovalid,odata,frame_err,overrun,rtsn}",
          {20'd0, ovalid, odata, frame_err, overrun, rtsn_pin},
          {20'd0, m_vld, m_dat, m_ferr, m_ovr, m_rts});
    if (rdy_mode) oready = ($urandom_range(0, 99) < rdy_pct);
    else          oready = rdy_val;
  endtask

  task automatic set_rdy(input logic v);
    rdy_mode = 1'b0;
    rdy_val  = v;
    oready   = v;
  endtask

  task automatic idle(input int k);
    rxd_pin = 1'b1;
    repeat (k) tick();
  endtask

  task automatic glitch(input int len);
    rxd_pin = 1'b0;
    repeat (len) tick();
    idle(10);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic sb, input int brk, input bit chk,
                            input logic ev, input logic [7:0] ed, input logic ef, input logic eo);
    logic [9:0] bits;
    int n;
    bits = {sb, b, 1'b0};
    n = cyc;
    ev_kind[n + STOP_OFS] = sb ? 1 : 2;
    ev_dat[n + STOP_OFS]  = b;
    for (int i = 0; i < 10; i++) begin
      rxd_pin = bits[i];
      if (i == 9 && chk) begin
        repeat (STOP_OFS - 9 * BC - 1) tick();
        if (!rdy_mode && rdy_val) check("ovalid low before stop sample", {31'd0, ovalid}, 32'd0);
        tick();
        check("stop ovalid", {31'd0, ovalid}, {31'd0, ev});
        if (ev) check("stop odata", {24'd0, odata}, {24'd0, ed});
        check("stop frame_err", {31'd0, frame_err}, {31'd0, ef});
        check("stop overrun", {31'd0, overrun}, {31'd0, eo});
        tick();
        check("pulses one cycle", {30'd0, frame_err, overrun}, 32'd0);
        check("rtsn follows ovalid", {31'd0, rtsn_pin}, {31'd0, ev});
        tick();
      end else begin
        repeat (BC) tick();
      end
    end
    if (brk > 0) begin
      rxd_pin = 1'b0;
      repeat (brk) tick();
    end
    rxd_pin = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pbits;
    vecs[0] = '{8'hA5, 1'b1, 0, 0,  4, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    vecs[1] = '{8'h01, 1'b1, 3, 0,  4, 1'b1, 1'b1, 8'h01, 1'b0, 1'b0};
    vecs[2] = '{8'h55, 1'b0, 0, 40, 4, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
    vecs[3] = '{8'hC3, 1'b1, 0, 0,  4, 1'b1, 1'b1, 8'hC3, 1'b0, 1'b0};
    vecs[4] = '{8'h00, 1'b1, 0, 0,  0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 1'b1, 0, 0,  0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};
    vecs[6] = '{8'h81, 1'b1, 0, 0,  4, 1'b1, 1'b1, 8'h81, 1'b0, 1'b0};
    vecs[7] = '{8'h5A, 1'b1, 0, 0,  0, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
    vecs[8] = '{8'hA6, 1'b0, 0, 0,  4, 1'b0, 1'b1, 8'h5A, 1'b1, 1'b0};
    vecs[9] = '{8'hE7, 1'b1, 0, 0,  4, 1'b1, 1'b1, 8'hE7, 1'b0, 1'b0};

    set_rdy(1'b0);
    repeat (3) tick();
    check("reset odata", {24'd0, odata}, 32'd0);
    check("reset ovalid", {31'd0, ovalid}, 32'd0);
    check("reset rtsn", {31'd0, rtsn_pin}, 32'd1);
    check("reset frame_err/overrun", {30'd0, frame_err, overrun}, 32'd0);
    resetn = 1'b1;
    tick();
    check("rtsn after reset release", {31'd0, rtsn_pin}, 32'd0);
    idle(5);

    for (int v = 0; v < 10; v++) begin
      set_rdy(vecs[v].rdy);
      if (vecs[v].glitch > 0) glitch(vecs[v].glitch);
      send_frame(vecs[v].dat, vecs[v].stop, vecs[v].brk, 1'b1,
                 vecs[v].exp_vld, vecs[v].exp_dat, vecs[v].exp_ferr, vecs[v].exp_ovr);
      idle(vecs[v].gap);
    end

    // Backpressure: second frame overruns, first byte held until drained.
    set_rdy(1'b0);
    send_frame(8'h3C, 1'b1, 0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b0);
    send_frame(8'h7E, 1'b1, 0, 1'b1, 1'b1, 8'h3C, 1'b0, 1'b1);
    idle(5);
    check("held ovalid", {31'd0, ovalid}, 32'd1);
    check("held odata", {24'd0, odata}, 32'h3C);
    check("held rtsn", {31'd0, rtsn_pin}, 32'd1);
    set_rdy(1'b1);
    tick();
    check("drain clears ovalid", {31'd0, ovalid}, 32'd0);
    idle(4);

    // Reset during data bit 4 with a byte pending.
    set_rdy(1'b0);
    send_frame(8'h99, 1'b1, 0, 1'b1, 1'b1, 8'h99, 1'b0, 1'b0);
    idle(3);
    pbits = 8'h42;
    rxd_pin = 1'b0;
    repeat (BC) tick();
    for (int i = 0; i < 4; i++) begin
      rxd_pin = pbits[i];
      repeat (BC) tick();
    end
    rxd_pin = pbits[4];
    repeat (HALF) tick();
    resetn = 1'b0;
    #1;
    check("midreset odata", {24'd0, odata}, 32'd0);
    check("midreset ovalid", {31'd0, ovalid}, 32'd0);
    check("midreset rtsn", {31'd0, rtsn_pin}, 32'd1);
    check("midreset pulses", {30'd0, frame_err, overrun}, 32'd0);
    rxd_pin = 1'b1;
    repeat (3) tick();
    resetn = 1'b1;
    tick();
    check("midreset rtsn after release", {31'd0, rtsn_pin}, 32'd0);
    set_rdy(1'b1);
    idle(3);
    send_frame(8'h42, 1'b1, 0, 1'b1, 1'b1, 8'h42, 1'b0, 1'b0);
    idle(4);

    // Randomized frames, glitches, breaks and ready patterns against the model.
    rdy_mode = 1'b1;
    for (int f = 0; f < 40; f++) begin
      bit bad;
      case ($urandom_range(0, 3))
        0: rdy_pct = 0;
        1: rdy_pct = 3;
        2: rdy_pct = 50;
        default: rdy_pct = 100;
      endcase
      if ($urandom_range(0, 5) == 0) glitch($urandom_range(1, 4));
      bad = ($urandom_range(0, 5) == 0);
      send_frame(8'($urandom_range(0, 255)), !bad, bad ? $urandom_range(0, 20) : 0, 1'b0,
                 1'b0, 8'h00, 1'b0, 1'b0);
      idle(bad ? 2 + $urandom_range(0, 3) : $urandom_range(0, 3));
    end
    rdy_pct = 100;
    idle(20);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
